// File: rtl/dmem_pkg.sv
// Shared types for the data-memory controller: size codes, FSM states, request latch, byte enables.
// No logic of its own.
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_BYTE = 2'b10,
    SIZE_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdat;
    logic        write;
    size_e       size;
  } req_t;

  function automatic logic [3:0] byte_en(input size_e size, input logic [1:0] lane);
    case (size)
      SIZE_WORD: return 4'b1111;
      SIZE_HALF: return 4'b0011 << lane;
      SIZE_BYTE: return 4'b0001 << lane;
      default:   return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_sram_bank.sv
// Single-port word SRAM with per-byte write enables; read data is registered (1-cycle latency).
// Always accepts an access when en is high; no backpressure.
module dmem_sram_bank #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdat,
  output logic [31:0]   rdat
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdat_d, rdat_q;

  always_comb begin
    rdat_d = rdat_q;
    if (en && !we) rdat_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    rdat_q <= rdat_d;
    if (en && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  assign rdat = rdat_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Core data-bus to SRAM controller: WAIT_CYCLES+2 stall cycles per access, result shown in DONE.
// Holds the core via ackd_n until DONE; dropping mreq during BUSY aborts the access.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dad,
  input  logic [31:0] ddt_wr,
  output logic [31:0] ddt_rd,
  output logic        ddt_rd_oe,
  input  logic        mreq,
  input  logic        write,
  input  logic [1:0]  size,
  output logic        ackd_n,
  output logic        fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;

  logic [31:0] offset, word_idx, sram_rdat;
  logic        req_fault, sram_en, done;

  // Fault is judged on the latched request so it is stable through BUSY and DONE.
  always_comb begin
    offset   = req_q.addr - BASE_ADDR;
    word_idx = offset >> 2;
    case (req_q.size)
      SIZE_WORD: req_fault = (req_q.addr[1:0] != 2'b00);
      SIZE_HALF: req_fault = req_q.addr[0];
      SIZE_BYTE: req_fault = 1'b0;
      default:   req_fault = 1'b1;
    endcase
    if (req_q.addr < BASE_ADDR || word_idx >= 32'(DEPTH_WORDS)) req_fault = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      IDLE: begin
        if (mreq) begin
          req_d   = '{addr: dad, wdat: ddt_wr, write: write, size: size_e'(size)};
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!mreq)              state_d = IDLE;
        else if (cnt_q == 4'd0) state_d = DONE;
        else                    cnt_d   = cnt_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset in the issue cycle must not let a store land in the array.
  always_comb begin
    sram_en   = (state_q == BUSY) && mreq && (cnt_q == 4'd0) && !req_fault && !rst;
    done      = (state_q == DONE);
    ackd_n    = ((state_q == IDLE) && mreq) || (state_q == BUSY);
    fault     = done && req_fault;
    ddt_rd_oe = done && !req_fault && !req_q.write;
    ddt_rd    = ddt_rd_oe ? sram_rdat : 32'd0;
  end

  dmem_sram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_sram (
    .clk  (clk),
    .en   (sram_en),
    .we   (req_q.write),
    .be   (byte_en(req_q.size, req_q.addr[1:0])),
    .addr (word_idx[AW-1:0]),
    .wdat (req_q.wdat),
    .rdat (sram_rdat)
  );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Two controllers (no wait / three wait cycles) driven by directed then random accesses,
// each DONE compared with a word-array memory model built from the access rules.
module tb_dmem_ctrl;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dad    [2];
  logic [31:0] ddt_wr [2];
  logic [31:0] ddt_rd [2];
  logic        ddt_rd_oe [2];
  logic        mreq   [2];
  logic        write  [2];
  logic [1:0]  size   [2];
  logic        ackd_n [2];
  logic        fault  [2];

  logic [31:0] mdl [2][DEPTH];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .dad(dad[0]), .ddt_wr(ddt_wr[0]), .ddt_rd(ddt_rd[0]),
    .ddt_rd_oe(ddt_rd_oe[0]), .mreq(mreq[0]), .write(write[0]), .size(size[0]),
    .ackd_n(ackd_n[0]), .fault(fault[0]));

  dmem_ctrl #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .dad(dad[1]), .ddt_wr(ddt_wr[1]), .ddt_rd(ddt_rd[1]),
    .ddt_rd_oe(ddt_rd_oe[1]), .mreq(mreq[1]), .write(write[1]), .size(size[1]),
    .ackd_n(ackd_n[1]), .fault(fault[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access on unit u. cut_k > 0 drops mreq (and raises rst if use_rst) in that cycle.
  task automatic access(input int u, input bit wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int cut_k, input bit use_rst, output logic [31:0] rd_obs);
    int          wt, c, nb, idx;
    bit          flt, quiet_bad;
    logic [31:0] exp_rd;
    logic [1:0]  lane;
    wt = (u == 0) ? 0 : 3;
    nb = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
    flt = (sz == 2'b11) || (a % nb != 0) || (a < BASE) || (a >= BASE + DEPTH * 4);
    idx = flt ? 0 : int'((a - BASE) >> 2);
    rd_obs = 32'd0;
    quiet_bad = 1'b0;
    @(negedge clk);
    mreq[u] = 1'b1; write[u] = wr; size[u] = sz; dad[u] = a; ddt_wr[u] = wd;
    c = 0;
    while (1) begin
      if (c > 0 && c == cut_k) begin
        mreq[u] = 1'b0;
        if (use_rst) rst = 1'b1;
        #1 check("cut_busy_ackd", 32'(ackd_n[u]), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("cut_idle_ackd", 32'(ackd_n[u]), 32'd0);
        check("cut_outputs", {ddt_rd[u][29:0], fault[u], ddt_rd_oe[u]}, 32'd0);
        return;
      end
      #1;
      if (ackd_n[u] == 1'b0) break;
      if (ddt_rd_oe[u] || fault[u] || ddt_rd[u] != 32'd0) quiet_bad = 1'b1;
      c++;
      if (c > 40) begin
        check("timeout_no_done", 32'(c), 32'(wt + 2));
        mreq[u] = 1'b0;
        return;
      end
      @(negedge clk);
    end
    exp_rd = (!flt && !wr) ? mdl[u][idx] : 32'd0;
    rd_obs = ddt_rd[u];
    check("stall_cycles", 32'(c), 32'(wt + 2));
    check("stall_quiet", 32'(quiet_bad), 32'd0);
    check("done_fault", 32'(fault[u]), 32'(flt));
    check("done_oe", 32'(ddt_rd_oe[u]), 32'(!flt && !wr));
    check("done_rd", ddt_rd[u], exp_rd);
    if (wr && !flt) begin
      for (int b = 0; b < nb; b++) begin
        lane = a[1:0] + 2'(b);
        mdl[u][idx][8*lane +: 8] = wd[8*lane +: 8];
      end
    end
  endtask

  task automatic drop(input int u);
    @(negedge clk);
    mreq[u] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, a, wd;
    logic [1:0]  sz;
    int          u, prev_u, kind, w, cut, wt;
    bit          keep, wr, ur;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dad[i] = '0; ddt_wr[i] = '0; mreq[i] = 1'b0; write[i] = 1'b0; size[i] = 2'b00;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_ackd", 32'(ackd_n[i]), 32'd0);
      check("rst_rd", ddt_rd[i], 32'd0);
      check("rst_oe", 32'(ddt_rd_oe[i]), 32'd0);
      check("rst_fault", 32'(fault[i]), 32'd0);
    end
    rst = 1'b0;

    // Fill both arrays so every later load has a defined expectation.
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        wd = $urandom;
        access(i, 1'b1, 2'b00, BASE + 32'(k * 4), wd, 0, 1'b0, rd);
      end
      drop(i);
    end

    access(0, 1'b1, 2'b00, BASE + 32'h10, 32'hDEADBEEF, 0, 1'b0, rd);
    access(0, 1'b0, 2'b00, BASE + 32'h10, 32'h0, 0, 1'b0, rd);
    check("dir_word_load", rd, 32'hDEADBEEF);
    access(0, 1'b1, 2'b10, BASE + 32'h12, 32'h00AA0000, 0, 1'b0, rd);
    access(0, 1'b0, 2'b00, BASE + 32'h10, 32'h0, 0, 1'b0, rd);
    check("dir_byte_merge", rd, 32'hDEAABEEF);
    access(0, 1'b0, 2'b01, BASE + 32'h11, 32'h0, 0, 1'b0, rd);
    drop(0);

    access(1, 1'b0, 2'b00, BASE + 32'h10, 32'h0, 0, 1'b0, rd);
    access(1, 1'b1, 2'b00, BASE + 32'h14, 32'h12345678, 2, 1'b0, rd);
    access(1, 1'b0, 2'b00, BASE + 32'h14, 32'h0, 0, 1'b0, rd);
    access(1, 1'b1, 2'b00, BASE + 32'h20, 32'hCAFEF00D, 2, 1'b1, rd);
    access(1, 1'b0, 2'b00, BASE + 32'h20, 32'h0, 0, 1'b0, rd);
    access(1, 1'b1, 2'b00, BASE + 32'h20, 32'h0BADF00D, 4, 1'b1, rd);
    access(1, 1'b0, 2'b00, BASE + 32'h20, 32'h0, 0, 1'b0, rd);
    drop(1);

    keep = 1'b0;
    prev_u = 0;
    for (int n = 0; n < 300; n++) begin
      u  = keep ? prev_u : int'($urandom_range(0, 1));
      wt = (u == 0) ? 0 : 3;
      wr = $urandom_range(0, 1) == 1;
      sz = 2'($urandom_range(0, 3));
      w  = $urandom_range(0, DEPTH - 1);
      kind = $urandom_range(0, 9);
      if (kind <= 6)
        a = BASE + 32'(w * 4) + ((sz == 2'b01) ? 32'(2 * $urandom_range(0, 1)) :
                                 (sz == 2'b10) ? 32'($urandom_range(0, 3)) : 32'd0);
      else if (kind == 7) a = BASE + 32'(w * 4) + 32'($urandom_range(0, 3));
      else if (kind == 8) a = BASE - 32'(4 * $urandom_range(1, 4));
      else                a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 15));
      wd  = $urandom;
      cut = ($urandom_range(0, 9) == 0) ? $urandom_range(1, wt + 1) : 0;
      ur  = $urandom_range(0, 1) == 1;
      access(u, wr, sz, a, wd, cut, ur, rd);
      prev_u = u;
      keep = (cut == 0) && ($urandom_range(0, 2) == 0);
      if (!keep && cut == 0) drop(u);
    end
    if (keep) drop(prev_u);

    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < DEPTH; k += 7) begin
        access(i, 1'b0, 2'b00, BASE + 32'(k * 4), 32'h0, 0, 1'b0, rd);
      end
      drop(i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller that sits directly downstream of the RV32I core's MEM stage. It consumes the core's data-bus request (DAD, DDT, MREQ, WRITE, SIZE) and runs each access against a word-organised, byte-enabled synchronous SRAM with a programmable wait time. It drives ACKD_n so the core's interlock holds the pipeline until the access completes. Misaligned and out-of-range accesses complete without touching memory and raise a fault pulse.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- DEPTH_WORDS, 4096: SRAM depth in 32-bit words (power of 2).
- WAIT_CYCLES, 0: extra busy cycles before the SRAM access is issued (0..15).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- dad  in  32  byte address from core (DAD).
- ddt_wr  in  32  store data from core, byte-lane aligned (lane = dad[1:0]).
- ddt_rd  out  32  load data to core, full word.
- ddt_rd_oe  out  1  high when ddt_rd must be driven onto DDT.
- mreq  in  1  access request (MREQ).
- write  in  1  1 = store, 0 = load (WRITE).
- size  in  2  2'b00 word, 2'b01 halfword, 2'b10 byte; 2'b11 is treated as a fault.
- ackd_n  out  1  0 = ready/complete, 1 = access in progress (ACKD_n).
- fault  out  1  one-cycle pulse: misaligned, out-of-range or size 2'b11 access.

## Operation
- FSM states:
  - IDLE: if mreq=1, latch dad/ddt_wr/write/size, load wait counter with WAIT_CYCLES, go to BUSY.
  - BUSY: decrement the counter each cycle; when counter==0, issue the SRAM access and go to DONE.
  - DONE: complete the access, then go to IDLE.
- Byte enables come from the latched size and dad[1:0]:
  - word: 4'b1111.
  - halfword: 4'b0011 << dad[1:0].
  - byte: 4'b0001 << dad[1:0].
- Word index = (dad - BASE_ADDR) >> 2.
- Fault conditions, evaluated on the latched request:
  - word with dad[1:0] != 0;
  - halfword with dad[0] = 1;
  - size = 2'b11;
  - dad < BASE_ADDR;
  - word index >= DEPTH_WORDS.
- A faulting access still passes through BUSY and DONE with identical timing, but:
  - no SRAM enable is asserted;
  - ddt_rd = 0 in DONE;
  - fault = 1 in DONE.
- Store: SRAM is written with the masked ddt_wr in the BUSY→DONE transition cycle. Bytes outside the enable mask are unchanged.
- Load: SRAM read is issued in the same cycle. Registered rdata is presented on ddt_rd in DONE.
- ddt_rd_oe = 1 only in DONE for a non-faulting load. At all other times ddt_rd_oe = 0 and ddt_rd = 0.
- ackd_n (combinational from state and mreq):
  - 1 in IDLE when mreq=1;
  - 1 throughout BUSY;
  - 0 in DONE;
  - 0 in IDLE when mreq=0.
- Abort: mreq=0 observed in BUSY returns the FSM to IDLE next cycle. No SRAM access is issued and there is no fault.
- Reset values: state IDLE, counter 0, ackd_n 0 (with mreq low), ddt_rd 0, ddt_rd_oe 0, fault 0. SRAM contents are not reset.

## Timing
- A request first seen in IDLE at cycle T:
  - BUSY from T+1 to T+1+WAIT_CYCLES;
  - DONE at T+2+WAIT_CYCLES.
- ackd_n stays 1 from T through T+1+WAIT_CYCLES, i.e. WAIT_CYCLES+2 stall cycles.
- The core captures load data / retires the store at the clock edge ending DONE.
- Back-to-back: mreq=1 in the IDLE cycle right after DONE is a new request. There are no idle bubbles beyond that IDLE cycle.
- Read-after-write to the same word returns the new data, because accesses are fully serialised.
- rst=1 in any state:
  - IDLE next cycle;
  - an in-flight store issued in that same cycle is suppressed;
  - an in-flight load never reaches DONE.

## Structure
- Shared package dmem_pkg holds:
  - size encodings (SIZE_WORD, SIZE_HALF, SIZE_BYTE);
  - FSM state enum (IDLE, BUSY, DONE);
  - the byte-enable function.
- One sub-module, dmem_sram_bank: DEPTH_WORDS×32 single-port synchronous SRAM with 4-bit byte-write enable and registered read data.
- The FSM, counter, request latch and fault logic live in dmem_ctrl.

## Test plan
- Reset with rst=1 for 2 cycles, mreq=0 → ackd_n=0, ddt_rd=0, ddt_rd_oe=0, fault=0.
- WAIT_CYCLES=0: store word 32'hDEADBEEF at BASE+0x10, then load the same address → ackd_n=1 for exactly 2 cycles each; load DONE shows ddt_rd=32'hDEADBEEF, ddt_rd_oe=1.
- Store byte at BASE+0x12 with ddt_wr=32'h00AA0000 over 32'hDEADBEEF, then load word → 32'hDEAABEEF.
- Halfword load at BASE+0x11 → same latency as a normal access; DONE gives fault=1, ddt_rd=0, ddt_rd_oe=0, SRAM enable never asserted.
- WAIT_CYCLES=3: load → ackd_n=1 for 5 cycles; drop mreq in the 2nd BUSY cycle on a store → FSM returns to IDLE, memory word unchanged.
- Assert rst in BUSY of a store to BASE+0x20 → IDLE next cycle; a subsequent load of BASE+0x20 returns the pre-store value.
